// File: rtl/seq_detect_param.sv
// Serial pattern detector: programmable PAT_W-bit pattern, Mealy match pulse, overlap select.
// Optional saturating match counter is built when SEQ_DETECT_CNT_EN is defined.
module seq_detect_param #(
    parameter int unsigned            PAT_W   = 4,
    parameter logic [PAT_W-1:0]       PAT_RST = PAT_W'(4'b1010),
    parameter int unsigned            CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             data_out,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned      FILL_W   = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-2:0]  hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  window_c;
    logic              match_c;

    // Candidate window: stored history plus the bit presented this cycle.
    assign window_c = {hist, data_in};
    assign match_c  = rst && data_valid && !pat_load
                      && (fill == FILL_MAX) && (window_c == pat_reg);
    assign data_out = match_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_reg <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
        end else if (pat_load) begin
            pat_reg <= pat_in;
            fill    <= '0;
        end else if (data_valid) begin
            hist <= window_c[PAT_W-2:0];
            // Non-overlapping mode needs a full set of fresh bits after a match.
            if (match_c && !overlap) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + FILL_W'(1);
            end
        end
    end

`ifdef SEQ_DETECT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    // Saturating match counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (match_c && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param; a second instance with CNT_W=2 checks saturation.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       data_in;
    logic       data_valid;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       data_out;
    logic [7:0] match_count;
    logic       data_out2;
    logic [1:0] match_count2;

    int checks   = 0;
    int failures = 0;

    seq_detect_param dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .data_out(data_out), .match_count(match_count)
    );

    seq_detect_param #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .data_out(data_out2), .match_count(match_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge; outputs settle 1 ns later.
    task automatic drive(input logic r, input logic d, input logic v,
                         input logic l, input logic [3:0] p);
        @(negedge clk);
        rst = r; data_in = d; data_valid = v; pat_load = l; pat_in = p;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        checks++;
        if (data_out !== 1'b0) begin
            failures++; $display("FAIL reset_data_out got=%b exp=0", data_out);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (match_count !== 8'd0) begin
            failures++; $display("FAIL reset_count got=%0d exp=0", match_count);
        end
    endtask

    task automatic test_overlap();
        logic [10:0] s, e;
        logic [7:0]  ec;
        s = 11'b10011010101; e = 11'b00000001010;
        ec = CNT_EN ? 8'd2 : 8'd0;
        overlap = 1'b1;
        do_reset();
        for (int i = 10; i >= 0; i--) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'h0);
            checks++;
            if (data_out !== e[i]) begin
                failures++; $display("FAIL overlap_bit%0d got=%b exp=%b", 11 - i, data_out, e[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (match_count !== ec) begin
            failures++; $display("FAIL overlap_count got=%0d exp=%0d", match_count, ec);
        end
    endtask

    task automatic test_non_overlap();
        logic [10:0] s, e;
        logic [7:0]  ec;
        s = 11'b10011010101; e = 11'b00000001000;
        ec = CNT_EN ? 8'd1 : 8'd0;
        overlap = 1'b0;
        do_reset();
        for (int i = 10; i >= 0; i--) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'h0);
            checks++;
            if (data_out !== e[i]) begin
                failures++; $display("FAIL nonoverlap_bit%0d got=%b exp=%b", 11 - i, data_out, e[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (match_count !== ec) begin
            failures++; $display("FAIL nonoverlap_count got=%0d exp=%0d", match_count, ec);
        end
        overlap = 1'b1;
    endtask

    task automatic test_pat_load();
        logic [6:0] s, e;
        logic [7:0] ec;
        s = 7'b1101101; e = 7'b0001001;
        ec = CNT_EN ? 8'd2 : 8'd0;
        overlap = 1'b1;
        do_reset();
        // 101 then a 0 with pat_load would complete 1010 if the load did not mask it.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1101);
        checks++;
        if (data_out !== 1'b0) begin
            failures++; $display("FAIL load_cycle_data_out got=%b exp=0", data_out);
        end
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'h0);
            checks++;
            if (data_out !== e[i]) begin
                failures++; $display("FAIL load_bit%0d got=%b exp=%b", 7 - i, data_out, e[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (match_count !== ec) begin
            failures++; $display("FAIL load_count got=%0d exp=%0d", match_count, ec);
        end
    endtask

    task automatic test_mid_reset();
        overlap = 1'b1;
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
        checks++;
        if (data_out !== 1'b0) begin
            failures++; $display("FAIL midreset_in_reset got=%b exp=0", data_out);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
        checks++;
        if (data_out !== 1'b0) begin
            failures++; $display("FAIL midreset_after got=%b exp=0", data_out);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (match_count !== 8'd0) begin
            failures++; $display("FAIL midreset_count got=%0d exp=0", match_count);
        end
    endtask

    task automatic test_saturate();
        logic [12:0] s, e;
        logic [1:0]  ec2;
        logic [7:0]  ec;
        s = 13'b1010101010101; e = 13'b0001010101010;
        ec2 = CNT_EN ? 2'd3 : 2'd0;
        ec  = CNT_EN ? 8'd5 : 8'd0;
        overlap = 1'b1;
        do_reset();
        for (int i = 12; i >= 0; i--) begin
            drive(1'b1, s[i], 1'b1, 1'b0, 4'h0);
            checks++;
            if (data_out2 !== e[i]) begin
                failures++; $display("FAIL sat_bit%0d got=%b exp=%b", 13 - i, data_out2, e[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (match_count2 !== ec2) begin
            failures++; $display("FAIL sat_count_w2 got=%0d exp=%0d", match_count2, ec2);
        end
        checks++;
        if (match_count !== ec) begin
            failures++; $display("FAIL sat_count_w8 got=%0d exp=%0d", match_count, ec);
        end
    endtask

    task automatic test_valid_gaps();
        logic [6:0] d, v, e;
        logic [7:0] ec;
        // Idle cycles carry the next data bit so an ignored data_valid would show.
        d = 7'b1001100; v = 7'b1010101; e = 7'b0000001;
        ec = CNT_EN ? 8'd1 : 8'd0;
        overlap = 1'b1;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive(1'b1, d[i], v[i], 1'b0, 4'h0);
            checks++;
            if (data_out !== e[i]) begin
                failures++; $display("FAIL gaps_cycle%0d got=%b exp=%b", 7 - i, data_out, e[i]);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
        checks++;
        if (match_count !== ec) begin
            failures++; $display("FAIL gaps_count got=%0d exp=%0d", match_count, ec);
        end
    endtask

    initial begin
        rst = 1'b0; data_in = 1'b0; data_valid = 1'b0;
        overlap = 1'b1; pat_load = 1'b0; pat_in = 4'h0;
        test_reset();
        test_overlap();
        test_non_overlap();
        test_pat_load();
        test_mid_reset();
        test_saturate();
        test_valid_gaps();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- PAT_W, 4, pattern length in bits; legal range 2..32.
- PAT_RST, 4'b1010, pattern loaded at reset; PAT_W bits wide.
- CNT_W, 8, match counter width in bits.
REQ-003 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- data_in  in  1  serial data bit, MSB of the pattern first.
- data_valid  in  1  data_in is sampled this cycle.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  in  1  load a new pattern this cycle.
- pat_in  in  PAT_W  new pattern value.
- data_out  out  1  Mealy match pulse.
- match_count  out  CNT_W  saturating count of matches.

Function
REQ-004 The block SHALL hold pat_reg (PAT_W bits), hist (PAT_W-1 bits, newest bit at LSB) and fill (a count of valid history bits, saturating at PAT_W-1).
REQ-005 data_out SHALL be combinational (Mealy) and SHALL equal data_valid AND NOT pat_load AND (fill == PAT_W-1) AND ({hist, data_in} == pat_reg).
REQ-006 When data_valid=1 and pat_load=0, the block SHALL, on the clock edge, shift data_in into hist and increment fill (saturating).
REQ-007 When data_valid=0, hist, fill and data_out SHALL hold, with data_out low.
REQ-008 On a match with overlap=1, hist and fill SHALL update per REQ-006, so that later matches may reuse the matched bits.
REQ-009 On a match with overlap=0, fill SHALL be cleared to 0 on that edge, so that the next match needs PAT_W fresh bits.
REQ-010 pat_load=1 SHALL capture pat_in into pat_reg and clear fill, with the following effects in that cycle:
- the data_in bit is discarded, even if data_valid=1;
- data_out is forced low.
REQ-011 The overlap input SHALL be sampled every cycle; a change takes effect from the next match evaluated.
REQ-012 Each cycle with data_out=1 SHALL increment match_count by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-013 No latency beyond REQ-005 SHALL exist: the match is flagged in the same cycle its last bit is presented.

Reset
REQ-014 When rst=0 at a clock edge, the block SHALL set pat_reg=PAT_RST, hist=0, fill=0 and match_count=0.
REQ-015 While rst=0, data_out SHALL be 0, regardless of the other inputs.
REQ-016 Reset mid-sequence SHALL discard any partial match; no match may span a reset.

Configuration
REQ-017 With macro SEQ_DETECT_CNT_EN defined, the match counter SHALL be implemented per REQ-012.
REQ-018 With SEQ_DETECT_CNT_EN undefined, the block SHALL have no counter flops, and match_count SHALL be tied to 0.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Default pattern 1010, overlap=1, data_valid=1, stream 10011010101 -> data_out high on the 8th and 10th bits only; match_count=2.
- Same stream with overlap=0 -> data_out high on the 8th bit only; match_count=1.
- pat_load with pat_in=4'b1101, then stream 1101101 with overlap=1 -> data_out high on the 4th and 7th bits; a data bit presented together with pat_load is ignored.
- Stream 101, then rst=0 for one cycle, then 0 -> no data_out pulse; match_count=0.
- CNT_W=2, overlap=1, stream 1010101010101 (5 matches) -> match_count saturates at 3.
- data_valid toggled low between each bit of 1010 -> a single match on the last valid bit; data_out is low in every data_valid=0 cycle.
- A build without SEQ_DETECT_CNT_EN -> match_count stays 0 while data_out still pulses.
